// File: rtl/phasenoisepon_sevenseg_seconds_if.sv
// Packed 8-in/8-out user-project bus for the seven-segment seconds counter.
// io_in = {data_in[3:0], ctl[1:0], rst_n, clk}; io_out = {dp, g, f, e, d, c, b, a}.
interface phasenoisepon_sevenseg_seconds_if;
    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (
        output io_in,
        input  io_out
    );

    modport slave (
        input  io_in,
        output io_out
    );
endinterface

// File: rtl/phasenoisepon_sevenseg_seconds.sv
// Seconds counter on one common-cathode seven-segment digit with a blinking decimal point.
// Define HEX_DIGITS_EN to count 0..F instead of 0..9.
module phasenoisepon_sevenseg_seconds #(
    parameter int MAX_COUNT = 10_000_000
) (
    phasenoisepon_sevenseg_seconds_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_UP    = 2'b00,
        MODE_DOWN  = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_PAUSE = 2'b11
    } mode_t;

    localparam logic [23:0] CNT_LAST = 24'(MAX_COUNT - 1);
    localparam logic [23:0] CNT_HALF = 24'(MAX_COUNT / 2);

`ifdef HEX_DIGITS_EN
    localparam logic [3:0] DIGIT_MAX = 4'hF;
`else
    localparam logic [3:0] DIGIT_MAX = 4'd9;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  ctl;
    logic [3:0]  data_in;
    mode_t       mode;

    logic [23:0] cnt;
    logic [23:0] cnt_next;
    logic [3:0]  digit;
    logic [3:0]  digit_next;
    logic        tick;
    logic [6:0]  segments;
    logic        dp;

    assign clk     = bus.io_in[0];
    assign rst_n   = bus.io_in[1];
    assign ctl     = bus.io_in[3:2];
    assign data_in = bus.io_in[7:4];
    assign mode    = mode_t'(ctl);

    function automatic logic [3:0] digit_up(input logic [3:0] d);
        return (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] digit_down(input logic [3:0] d);
        return (d == 4'd0) ? DIGIT_MAX : d - 4'd1;
    endfunction

    // Decimal builds saturate out-of-range load values to 9.
    function automatic logic [3:0] load_value(input logic [3:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] seg;
        seg = 7'h00;
        case (d)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
`ifdef HEX_DIGITS_EN
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
`endif
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    assign tick = ((mode == MODE_UP) || (mode == MODE_DOWN)) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 24'd0;
            digit <= 4'd0;
        end else begin
            cnt   <= cnt_next;
            digit <= digit_next;
        end
    end

    // Load re-arms the prescaler every clock so no tick can fire while it is held.
    always_comb begin
        cnt_next   = cnt;
        digit_next = digit;
        case (mode)
            MODE_UP: begin
                cnt_next = tick ? 24'd0 : cnt + 24'd1;
                if (tick) digit_next = digit_up(digit);
            end
            MODE_DOWN: begin
                cnt_next = tick ? 24'd0 : cnt + 24'd1;
                if (tick) digit_next = digit_down(digit);
            end
            MODE_LOAD: begin
                cnt_next   = 24'd0;
                digit_next = load_value(data_in);
            end
            MODE_PAUSE: begin
                cnt_next   = cnt;
                digit_next = digit;
            end
            default: begin
                cnt_next   = cnt;
                digit_next = digit;
            end
        endcase
    end

    assign segments   = decode(digit);
    assign dp         = (cnt < CNT_HALF);
    assign bus.io_out = {dp, segments};

endmodule

// File: tb/tb_phasenoisepon_sevenseg_seconds.sv
// Directed bench for the seven-segment seconds counter with MAX_COUNT=100.
// Expected io_out bytes are {dp, segments} worked out by hand for each step.
module tb_phasenoisepon_sevenseg_seconds;

    logic       clk;
    logic       rst_n;
    logic [1:0] ctl;
    logic [3:0] data_in;
    int         total;
    int         bad;

    phasenoisepon_sevenseg_seconds_if bus ();

    assign bus.io_in = {data_in, ctl, rst_n, clk};

    phasenoisepon_sevenseg_seconds #(.MAX_COUNT(100)) dut (
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: io_out=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] new_ctl, input logic [3:0] new_data);
        ctl     = new_ctl;
        data_in = new_data;
    endtask

    // Let n rising edges pass, then park on the following falling edge to sample.
    task automatic runEdges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        applyStimulus(2'b00, 4'h0);

        repeat (3) @(negedge clk);
        checkOutput("reset_value", bus.io_out, 8'hBF);

        rst_n = 1'b1;
        runEdges(99);
        checkOutput("edge99_no_tick", bus.io_out, 8'h3F);
        runEdges(1);
        checkOutput("edge100_digit1", bus.io_out, 8'h86);
        runEdges(49);
        checkOutput("edge149_dp_high", bus.io_out, 8'h86);
        runEdges(1);
        checkOutput("edge150_dp_low", bus.io_out, 8'h06);
        runEdges(50);
        checkOutput("edge200_digit2", bus.io_out, 8'hDB);
        runEdges(799);
        checkOutput("edge999_digit9", bus.io_out, 8'h6F);
        runEdges(1);
        checkOutput("edge1000_wrap0", bus.io_out, 8'hBF);

        applyStimulus(2'b10, 4'h7);
        runEdges(1);
        checkOutput("load7", bus.io_out, 8'h87);
        applyStimulus(2'b01, 4'h7);
        runEdges(99);
        checkOutput("down_pre_tick", bus.io_out, 8'h07);
        runEdges(1);
        checkOutput("down_to6", bus.io_out, 8'hFD);

        applyStimulus(2'b10, 4'h0);
        runEdges(1);
        checkOutput("load0", bus.io_out, 8'hBF);
        applyStimulus(2'b01, 4'h0);
        runEdges(100);
        checkOutput("down_wrap", bus.io_out, 8'hEF);

        applyStimulus(2'b10, 4'hC);
        runEdges(150);
`ifdef HEX_DIGITS_EN
        checkOutput("loadC_held", bus.io_out, 8'hB9);
`else
        checkOutput("loadC_saturate", bus.io_out, 8'hEF);
`endif

        applyStimulus(2'b10, 4'h3);
        runEdges(1);
        checkOutput("load3", bus.io_out, 8'hCF);
        applyStimulus(2'b00, 4'h3);
        runEdges(60);
        checkOutput("run60", bus.io_out, 8'h4F);
        applyStimulus(2'b11, 4'h3);
        runEdges(500);
        checkOutput("pause500", bus.io_out, 8'h4F);
        applyStimulus(2'b00, 4'h3);
        runEdges(39);
        checkOutput("resume_pre_tick", bus.io_out, 8'h4F);
        runEdges(1);
        checkOutput("resume_tick", bus.io_out, 8'hE6);

        applyStimulus(2'b10, 4'h5);
        runEdges(1);
        applyStimulus(2'b00, 4'h5);
        runEdges(30);
        checkOutput("digit5_mid", bus.io_out, 8'hED);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", bus.io_out, 8'hBF);
        runEdges(2);
        checkOutput("reset_held", bus.io_out, 8'hBF);
        rst_n = 1'b1;
        runEdges(99);
        checkOutput("after_reset_pre_tick", bus.io_out, 8'h3F);
        runEdges(1);
        checkOutput("after_reset_tick", bus.io_out, 8'h86);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
